// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
// Serial PRBS-8 checker (x^8+x^6+x^5+x^4+1, period 255).
//
// Consumes one bit per i_valid cycle. It starts in HUNT and fills its history.
// It then moves to SYNC, where it needs LOCK_CNT consecutive correct
// predictions from a non-zero history before it declares LOCKED. While LOCKED
// it counts mismatches. UNLOCK_ERRS consecutive mismatches drop it back to HUNT.
//
// The history register always shifts in the received bit, never the predicted
// bit. This makes the checker self-synchronising. As a result, one flipped
// line bit shows up as 1 + popcount(TAPS) mismatches.
//
// Optional build macro PRBS_CHECKER_BIT_CNT_EN adds o_bit_cnt. This is a
// 32-bit saturating count of the valid bits consumed while LOCKED, used
// together with o_err_cnt for BER measurement.
// -----------------------------------------------------------------------------
module prbs_checker #(
  parameter logic [7:0]  TAPS        = 8'b1011_1000,
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned UNLOCK_ERRS = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_clr_cnt,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [CNT_W-1:0] o_err_cnt
`ifdef PRBS_CHECKER_BIT_CNT_EN
  ,
  output logic [31:0]      o_bit_cnt
`endif
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Terminal values of the run counters. Each counter is compared against
  // (target - 1) so that the transition happens on the edge that consumes
  // the deciding bit.
  localparam logic [3:0] FILL_LAST   = 4'd7;
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_ERRS - 1);

  state_t     state;
  logic [7:0] hist;        // hist[0] = newest bit, hist[7] = 8 valid bits ago
  logic [3:0] fill_cnt;    // valid bits seen in HUNT
  logic [7:0] match_cnt;   // consecutive good predictions in SYNC
  logic [3:0] miss_cnt;    // consecutive mispredictions in LOCKED

  logic pred_bit;
  logic bit_match;
  logic hist_zero;
  logic err_event;

  // Saturating increment for the error counter: it holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc_err(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = (&v) ? v : v + 1'b1;
    return r;
  endfunction

  // Saturating increment for the 32-bit consumed-bit counter.
  function automatic logic [31:0] sat_inc_bits(input logic [31:0] v);
    logic [31:0] r;
    r = (&v) ? v : v + 32'd1;
    return r;
  endfunction

  // Predict the next bit from the history as it stands before the shift.
  always_comb begin
    pred_bit  = ^(hist & TAPS);
    bit_match = (i_bit == pred_bit);
    hist_zero = (hist == 8'h00);
    err_event = i_valid && (state == LOCKED) && !bit_match;
  end

  // Receive history. The received bit is shifted in on every valid cycle,
  // whatever the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 8'h00;
    end else if (i_valid) begin
      hist <= {hist[6:0], i_bit};
    end
  end

  // HUNT / SYNC / LOCKED sequencing, with the registered lock flag and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      fill_cnt    <= 4'd0;
      match_cnt   <= 8'd0;
      miss_cnt    <= 4'd0;
      o_locked    <= 1'b0;
      o_err_pulse <= 1'b0;
    end else begin
      o_err_pulse <= 1'b0;
      if (i_valid) begin
        case (state)
          HUNT: begin
            if (fill_cnt == FILL_LAST) begin
              state     <= SYNC;
              fill_cnt  <= 4'd0;
              match_cnt <= 8'd0;
            end else begin
              fill_cnt <= fill_cnt + 4'd1;
            end
          end
          SYNC: begin
            // An all-zero history predicts zero forever. Such a bit is never
            // credited as a match, so a dead (stuck-at-0) line cannot lock.
            if (bit_match && !hist_zero) begin
              if (match_cnt == LOCK_LAST) begin
                state     <= LOCKED;
                o_locked  <= 1'b1;
                match_cnt <= 8'd0;
                miss_cnt  <= 4'd0;
              end else begin
                match_cnt <= match_cnt + 8'd1;
              end
            end else begin
              match_cnt <= 8'd0;
            end
          end
          LOCKED: begin
            if (bit_match) begin
              miss_cnt <= 4'd0;
            end else begin
              o_err_pulse <= 1'b1;
              if (miss_cnt == UNLOCK_LAST) begin
                state    <= HUNT;
                o_locked <= 1'b0;
                fill_cnt <= 4'd0;
                miss_cnt <= 4'd0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end
          end
          default: begin
            state    <= HUNT;
            fill_cnt <= 4'd0;
            o_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Error counter. A clear takes priority over an error in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_err_cnt <= '0;
    end else if (err_event) begin
      o_err_cnt <= sat_inc_err(o_err_cnt);
    end
  end

`ifdef PRBS_CHECKER_BIT_CNT_EN
  // Count the bits consumed while LOCKED; this is the BER denominator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_bit_cnt <= 32'd0;
    end else if (i_clr_cnt) begin
      o_bit_cnt <= 32'd0;
    end else if (i_valid && (state == LOCKED)) begin
      o_bit_cnt <= sat_inc_bits(o_bit_cnt);
    end
  end
`else
  // The default build has no consumed-bit counter.
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_checker
// Self-checking bench for prbs_checker. The bench has two instances: the
// default CNT_W=16 build and a CNT_W=4 copy for the saturation check. Both are
// driven with the same stimulus. Stimulus comes from a PRBS generator written
// as the polynomial recurrence. Expected outputs come from a sequence-level
// reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prbs_checker;

  localparam int LOCK_CNT    = 16;
  localparam int UNLOCK_ERRS = 4;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        i_bit;
  logic        i_clr_cnt;
  logic        o_locked, o_err_pulse;
  logic [15:0] o_err_cnt;
  logic        locked4, pulse4;
  logic [3:0]  err4;
`ifdef PRBS_CHECKER_BIT_CNT_EN
  logic [31:0] o_bit_cnt, bit_cnt4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  prbs_checker u_dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_bit(i_bit),
    .i_clr_cnt(i_clr_cnt), .o_locked(o_locked), .o_err_pulse(o_err_pulse),
    .o_err_cnt(o_err_cnt)
`ifdef PRBS_CHECKER_BIT_CNT_EN
    , .o_bit_cnt(o_bit_cnt)
`endif
  );

  prbs_checker #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_bit(i_bit),
    .i_clr_cnt(i_clr_cnt), .o_locked(locked4), .o_err_pulse(pulse4),
    .o_err_cnt(err4)
`ifdef PRBS_CHECKER_BIT_CNT_EN
    , .o_bit_cnt(bit_cnt4)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stimulus generator: b[n] = b[n-8]^b[n-6]^b[n-5]^b[n-4]
  bit gq[$];

  task automatic gen_seed();
    gq.delete();
    for (int k = 0; k < 8; k++) gq.push_back(bit'($urandom_range(0, 1)));
    gq[0] = 1'b1;  // guarantee a non-zero seed
  endtask

  function automatic bit gen_next();
    bit nb;
    nb = gq[0] ^ gq[2] ^ gq[3] ^ gq[4];
    void'(gq.pop_front());
    gq.push_back(nb);
    return nb;
  endfunction

  // ---------------- reference model (sequence level)
  int     m_phase;     // 0 = hunting, 1 = syncing, 2 = locked
  int     m_since, m_run, m_miss;
  longint m_err, m_bits;
  bit     m_pulse;
  bit     rx_q[$];     // received valid bits since reset, oldest first

  task automatic model_reset();
    m_phase = 0; m_since = 0; m_run = 0; m_miss = 0;
    m_err = 0; m_bits = 0; m_pulse = 0;
    rx_q.delete();
  endtask

  task automatic model_update(input bit v, input bit b, input bit clr);
    bit err, pred, zero, was_locked;
    err = 0; pred = 0; zero = 1;
    was_locked = (m_phase == 2);
    if (v) begin
      if (rx_q.size() >= 8) begin
        pred = rx_q[$-7] ^ rx_q[$-5] ^ rx_q[$-4] ^ rx_q[$-3];
        for (int k = 0; k < 8; k++) if (rx_q[$-k]) zero = 0;
      end
      case (m_phase)
        0: begin
          m_since++;
          if (m_since == 8) begin m_phase = 1; m_run = 0; end
        end
        1: begin
          if (b == pred && !zero) begin
            m_run++;
            if (m_run == LOCK_CNT) begin m_phase = 2; m_miss = 0; end
          end else m_run = 0;
        end
        default: begin
          if (b == pred) m_miss = 0;
          else begin
            err = 1;
            m_miss++;
            if (m_miss == UNLOCK_ERRS) begin m_phase = 0; m_since = 0; end
          end
        end
      endcase
      rx_q.push_back(b);
      if (rx_q.size() > 16) void'(rx_q.pop_front());
    end
    m_pulse = err;
    if (clr) begin
      m_err = 0; m_bits = 0;
    end else begin
      m_err += longint'(err);
      if (v && was_locked) m_bits++;
    end
  endtask

  function automatic logic [15:0] exp_err16();
    return (m_err > 65535) ? 16'hFFFF : 16'(m_err);
  endfunction

  function automatic logic [3:0] exp_err4();
    return (m_err > 15) ? 4'hF : 4'(m_err);
  endfunction

  // ---------------- drivers
  task automatic step(input bit v, input bit b, input bit clr);
    i_valid = v; i_bit = b; i_clr_cnt = clr;
    @(posedge clk);
    model_update(v, b, clr);
    #1;
  endtask

  task automatic do_reset();
    i_valid = 0; i_bit = 0; i_clr_cnt = 0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests
  task automatic test_reset();
    i_valid = 0; i_bit = 0; i_clr_cnt = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", o_locked); end
    n_checks++; if (o_err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", o_err_pulse); end
    n_checks++; if (o_err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", o_err_cnt); end
    n_checks++; if (err4 !== 4'd0) begin n_fail++; $display("FAIL reset_err4: got %0d want 0", err4); end
`ifdef PRBS_CHECKER_BIT_CNT_EN
    n_checks++; if (o_bit_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d want 0", o_bit_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock_clean();
    int bad;
    do_reset();
    gen_seed();
    for (int i = 1; i <= 24; i++) begin
      step(1, gen_next(), 0);
      if (i == 23) begin
        n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: locked=%b after 23 bits want 0", o_locked); end
      end
      if (i == 24) begin
        n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL lock_at_24: locked=%b after 24 bits want 1", o_locked); end
      end
    end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1, gen_next(), 0);
      if (o_locked !== 1'b1 || o_err_cnt !== 16'd0 || o_err_pulse !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL clean_1000: %0d bad cycles, last err_cnt=%0d want 0", bad, o_err_cnt); end
  endtask

  task automatic test_single_flip();
    logic [15:0] e0;
    int pulses[$];
    bit b;
    e0 = o_err_cnt;
    for (int i = 0; i < 20; i++) begin
      b = gen_next();
      if (i == 2) b = ~b;
      step(1, b, 0);
      if (o_err_pulse === 1'b1) pulses.push_back(i);
      n_checks++; if (o_err_pulse !== m_pulse) begin n_fail++; $display("FAIL flip_pulse_%0d: got %b want %b", i, o_err_pulse, m_pulse); end
    end
    n_checks++; if (o_err_cnt !== e0 + 16'd5) begin n_fail++; $display("FAIL flip_err_delta: got %0d want %0d", o_err_cnt, e0 + 16'd5); end
    n_checks++; if (pulses.size() != 5) begin n_fail++; $display("FAIL flip_pulse_count: got %0d want 5", pulses.size()); end
    else begin
      n_checks++;
      if (pulses[1]-pulses[0] != 4 || pulses[2]-pulses[1] != 1 || pulses[3]-pulses[2] != 1 || pulses[4]-pulses[3] != 2) begin
        n_fail++;
        $display("FAIL flip_gaps: got %0d,%0d,%0d,%0d want 4,1,1,2", pulses[1]-pulses[0], pulses[2]-pulses[1], pulses[3]-pulses[2], pulses[4]-pulses[3]);
      end
    end
    n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL flip_keeps_lock: got %b want 1", o_locked); end
  endtask

  task automatic test_inverted();
    logic [15:0] e0;
    int bad;
    e0 = o_err_cnt;
    for (int i = 1; i <= 4; i++) begin
      step(1, ~gen_next(), 0);
      if (i == 3) begin
        n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL inv_lock_after3: got %b want 1", o_locked); end
      end
    end
    n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL inv_unlock: got %b want 0", o_locked); end
    n_checks++; if (o_err_cnt !== e0 + 16'd4) begin n_fail++; $display("FAIL inv_err_delta: got %0d want %0d", o_err_cnt, e0 + 16'd4); end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step(1, ~gen_next(), 0);
      if (o_locked !== 1'b0 || o_err_pulse !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL inv_never_relock: %0d bad cycles want 0", bad); end
    n_checks++; if (o_err_cnt !== e0 + 16'd4) begin n_fail++; $display("FAIL inv_err_hold: got %0d want %0d", o_err_cnt, e0 + 16'd4); end
  endtask

  task automatic test_zero_stream();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      step(1, 0, 0);
      if (o_locked !== 1'b0 || o_err_cnt !== 16'd0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL zero_stream: %0d bad cycles, locked=%b err=%0d want 0,0", bad, o_locked, o_err_cnt); end
  endtask

  task automatic test_clr_cnt();
    bit b;
    do_reset();
    gen_seed();
    for (int i = 0; i < 24; i++) step(1, gen_next(), 0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 12; i++) begin
        b = gen_next();
        if (i == 0) b = ~b;
        step(1, b, 0);
      end
    end
    n_checks++; if (o_err_cnt !== 16'd20) begin n_fail++; $display("FAIL accum_err16: got %0d want 20", o_err_cnt); end
    n_checks++; if (err4 !== 4'd15) begin n_fail++; $display("FAIL sat_err4: got %0d want 15", err4); end
    for (int i = 0; i < 12; i++) begin
      b = gen_next();
      if (i == 0) b = ~b;
      step(1, b, 0);
    end
    n_checks++; if (err4 !== 4'd15) begin n_fail++; $display("FAIL sat_hold_err4: got %0d want 15", err4); end
    n_checks++; if (o_err_cnt !== 16'd25) begin n_fail++; $display("FAIL accum2_err16: got %0d want 25", o_err_cnt); end
    // clear coinciding with a mismatch
    step(1, ~gen_next(), 1);
    n_checks++; if (o_err_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_wins: got %0d want 0", o_err_cnt); end
    n_checks++; if (o_err_pulse !== 1'b1) begin n_fail++; $display("FAIL clr_pulse: got %b want 1", o_err_pulse); end
    n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL clr_locked: got %b want 1", o_locked); end
    n_checks++; if (err4 !== 4'd0) begin n_fail++; $display("FAIL clr_err4: got %0d want 0", err4); end
    for (int i = 0; i < 10; i++) step(1, gen_next(), 0);
    n_checks++; if (o_err_cnt !== 16'd4) begin n_fail++; $display("FAIL clr_echoes: got %0d want 4", o_err_cnt); end
  endtask

  task automatic test_valid_toggle();
    int vcnt, bad;
    bit v;
    do_reset();
    gen_seed();
    vcnt = 0; bad = 0;
    for (int c = 0; c < 100 && vcnt < 24; c++) begin
      v = (c % 2) == 0;
      step(v, v ? gen_next() : bit'($urandom_range(0, 1)), 0);
      if (v) begin
        vcnt++;
        if (vcnt == 23) begin
          n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL vt_lock_early: got %b want 0", o_locked); end
        end
        if (vcnt == 24) begin
          n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL vt_lock_at_24: got %b want 1", o_locked); end
        end
      end else if (o_err_pulse !== 1'b0) bad++;
    end
    n_checks++; if (vcnt != 24) begin n_fail++; $display("FAIL vt_budget: got %0d valid bits want 24", vcnt); end
    for (int c = 0; c < 40; c++) begin
      v = (c % 2) == 0;
      step(v, v ? gen_next() : bit'($urandom_range(0, 1)), 0);
      if (o_locked !== 1'b1 || o_err_cnt !== 16'd0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL vt_idle_cycles: %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    step(1, ~gen_next(), 0);  // one error so the outputs are non-zero
    n_checks++; if (o_err_pulse !== 1'b1) begin n_fail++; $display("FAIL rm_pre_pulse: got %b want 1", o_err_pulse); end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL rm_locked: got %b want 0", o_locked); end
    n_checks++; if (o_err_pulse !== 1'b0) begin n_fail++; $display("FAIL rm_pulse: got %b want 0", o_err_pulse); end
    n_checks++; if (o_err_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_err_cnt: got %0d want 0", o_err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step(1, gen_next(), 0);
      if (i == 23) begin
        n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL rm_relock_early: got %b want 0", o_locked); end
      end
    end
    n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL rm_relock_24: got %b want 1", o_locked); end
  endtask

  task automatic test_random();
    bit v, b, clr;
    int burst;
    do_reset();
    gen_seed();
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 199) == 0);
      b   = 1'b0;
      if (v) begin
        b = gen_next();
        if (burst > 0) begin b = ~b; burst--; end
        else if ($urandom_range(0, 499) == 0) begin burst = 5; b = ~b; end
        else if ($urandom_range(0, 47) == 0) b = ~b;
      end
      step(v, b, clr);
      n_checks++; if (o_locked !== (m_phase == 2)) begin n_fail++; $display("FAIL rnd_locked @%0d: got %b want %b", c, o_locked, (m_phase == 2)); end
      n_checks++; if (o_err_pulse !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse @%0d: got %b want %b", c, o_err_pulse, m_pulse); end
      n_checks++; if (o_err_cnt !== exp_err16()) begin n_fail++; $display("FAIL rnd_err16 @%0d: got %0d want %0d", c, o_err_cnt, exp_err16()); end
      n_checks++; if (err4 !== exp_err4()) begin n_fail++; $display("FAIL rnd_err4 @%0d: got %0d want %0d", c, err4, exp_err4()); end
`ifdef PRBS_CHECKER_BIT_CNT_EN
      n_checks++; if (o_bit_cnt !== 32'(m_bits)) begin n_fail++; $display("FAIL rnd_bit_cnt @%0d: got %0d want %0d", c, o_bit_cnt, m_bits); end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b1; i_valid = 0; i_bit = 0; i_clr_cnt = 0;
    model_reset();
    test_reset();
    test_lock_clean();
    test_single_flip();
    test_inverted();
    test_zero_stream();
    test_clr_cnt();
    test_valid_toggle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
